// File: rtl/piso_shiftreg.sv
// Parallel-in, serial-out transmitter with valid/ready load and back-to-back streaming.
// Optional even-parity trailer cycle when PISO_PARITY_EN is defined.
module piso_shiftreg #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int LAST = WIDTH + 1;
`else
   localparam int LAST = WIDTH;
`endif
   localparam int CW = $clog2(LAST + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(LAST);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
`ifdef PISO_PARITY_EN
   localparam logic [CW-1:0] PAR_CNT  = CW'(WIDTH);
`endif

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             accept;
   logic             first_bit, next_bit;
   logic [WIDTH-1:0] load_rest, shifted;

   // State register.
   // NOTE: async reset clears every register, so a partial word can never resume.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         sout_q   <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         sout_q   <= sout_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Bit-order selection: the shift register always holds the bits still to be sent.
   always_comb begin
      if (MSB_FIRST) begin
         first_bit = din[WIDTH-1];
         load_rest = din << 1;
         next_bit  = shreg_q[WIDTH-1];
         shifted   = shreg_q << 1;
      end else begin
         first_bit = din[0];
         load_rest = din >> 1;
         next_bit  = shreg_q[0];
         shifted   = shreg_q >> 1;
      end
   end

   assign accept = load_valid && load_ready;

   // Next-state logic.
   always_comb begin
      // NOTE: hold-by-default assignments keep this block free of inferred latches.
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      sout_d   = sout_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
`ifdef PISO_PARITY_EN
      parity_d = parity_q;
`endif
      if (accept) begin
         state_d  = SHIFT;
         cnt_d    = ONE_CNT;
         shreg_d  = load_rest;
         sout_d   = first_bit;
         valid_d  = 1'b1;
         busy_d   = 1'b1;
`ifdef PISO_PARITY_EN
         parity_d = ^din;
`endif
      end else if (state_q == SHIFT) begin
         if (cnt_q != LAST_CNT) begin
            cnt_d   = cnt_q + ONE_CNT;
            shreg_d = shifted;
            sout_d  = next_bit;
`ifdef PISO_PARITY_EN
            if (cnt_q == PAR_CNT) sout_d = parity_q;
`endif
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      end
   end

   // Outputs: handshake and done decode from registered state only.
   always_comb begin
      load_ready = (state_q == IDLE) || (cnt_q == LAST_CNT);
      done       = (state_q == SHIFT) && (cnt_q == LAST_CNT);
      sout       = sout_q;
      sout_valid = valid_q;
      busy       = busy_q;
   end

endmodule

// File: tb/tb_piso_shiftreg.sv
// Randomised bench for piso_shiftreg, compared against a bit-queue reference model.
// Honours PISO_PARITY_EN so the model tracks the parity trailer when it is built in.
module tb_piso_shiftreg;

   localparam int WIDTH     = 4;
   localparam bit MSB_FIRST = 1'b0;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] din;
   logic             sout, sout_valid, busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bits still to appear on sout, current bit at the front.
   bit               exp_q[$];
   logic [WIDTH-1:0] words_q[$];
   logic [WIDTH-1:0] rx;

   piso_shiftreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .din        (din),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_outputs();
      bit active;
      active = (exp_q.size() != 0);
      check("sout_valid", sout_valid, active);
      check("busy", busy, active);
      check("sout", sout, active ? exp_q[0] : 1'b0);
      check("done", done, active && exp_q.size() == 1);
      check("load_ready", load_ready, !active || exp_q.size() == 1);
      if (sout_valid) rx = {sout, rx[WIDTH-1:1]};
`ifndef PISO_PARITY_EN
      if (active && exp_q.size() == 1 && words_q.size() != 0) begin
         check("rx_word", rx, words_q[0]);
         void'(words_q.pop_front());
      end
`endif
   endtask

   // One clock cycle: check current outputs, drive inputs, advance the model at the edge.
   task automatic cycle(input logic lv, input logic [WIDTH-1:0] d);
      bit ready;
      check_outputs();
      load_valid = lv;
      din        = d;
      ready      = (exp_q.size() <= 1);
      @(posedge clk);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (lv && ready) begin
         for (int i = 0; i < WIDTH; i++)
            exp_q.push_back(MSB_FIRST ? d[WIDTH-1-i] : d[i]);
`ifdef PISO_PARITY_EN
         exp_q.push_back(^d);
`endif
         words_q.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic reset_model();
      exp_q.delete();
      words_q.delete();
      rx = '0;
   endtask

   initial begin
      rst        = 1'b0;
      load_valid = 1'b1;
      din        = 4'hF;
      reset_model();
      #1;
      check("rst_sout", sout, 1'b0);
      check("rst_valid", sout_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", load_ready, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      load_valid = 1'b0;

      // Idle after release: nothing emitted without an accept.
      cycle(1'b0, 4'hF);
      cycle(1'b0, 4'hF);

      // Single word 0001, then idle.
      cycle(1'b1, 4'b0001);
      repeat (WIDTH + 2) cycle(1'b0, 4'h0);

      // Back-to-back A then 5 with load_valid held high until 5 is taken.
      cycle(1'b1, 4'hA);
      repeat (WIDTH) cycle(1'b1, 4'h5);
      repeat (WIDTH + 2) cycle(1'b0, 4'h0);

      // Load pulse during bit 2 must be ignored.
      cycle(1'b1, 4'hC);
      cycle(1'b0, 4'h0);
      cycle(1'b1, 4'h3);
      repeat (WIDTH + 1) cycle(1'b0, 4'h0);

      // Asynchronous reset during bit 2.
      cycle(1'b1, 4'hF);
      cycle(1'b0, 4'h0);
      check_outputs();
      #2 rst = 1'b0;
      #1;
      check("arst_sout", sout, 1'b0);
      check("arst_valid", sout_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_ready", load_ready, 1'b1);
      reset_model();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cycle(1'b0, 4'h0);

      // Random streaming.
      for (int n = 0; n < 400; n++)
         cycle(1'($urandom_range(0, 2) != 0), 4'($urandom));
      repeat (WIDTH + 2) cycle(1'b0, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
